// File: rtl/cnn_fifo_pkg.sv
// Shared types and helpers for the multi-channel CNN input FIFO.
// Latency: n/a (package). Backpressure: n/a.
// Acceptance widths, pointer sizing and per-channel status layout.
package cnn_fifo_pkg;

    // Width used when comparing a channel index against the channel count.
    localparam int CH_CMP_W     = 32;
    // Count field is sized for any realistic depth; the top keeps only PTR_W+1 bits.
    localparam int STATUS_CNT_W = 16;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic chan_in_range(input logic [CH_CMP_W-1:0] ch, input int num_ch);
        return ch < CH_CMP_W'(num_ch);
    endfunction

    typedef struct packed {
        logic                    full;
        logic                    empty;
        logic                    almost_full;
        logic [STATUS_CNT_W-1:0] count;
    } ch_status_t;

endpackage

// File: rtl/fifo_channel_ctrl.sv
// Per-channel pointer pair with flags and occupancy derived from registered pointers.
// Latency: pointers move at the edge after push_ok/pop_ok; flags are combinational from them.
// Backpressure: none; the caller only asserts push_ok/pop_ok when the request is legal.
module fifo_channel_ctrl
    import cnn_fifo_pkg::*;
#(
    parameter int  FIFO_DEPTH        = 8,
    parameter int  ALMOST_FULL_LEVEL = 6,
    localparam int PTR_W             = ptr_width(FIFO_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_ok_i,
    input  logic             pop_ok_i,
    input  logic             flush_i,
    output ch_status_t       status_o,
    output logic [PTR_W-1:0] waddr_o,
    output logic [PTR_W-1:0] raddr_o
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] AF_LVL  = (PTR_W+1)'(ALMOST_FULL_LEVEL);

    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;
    logic [PTR_W:0] count;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok_i) wptr_d = wptr_q + PTR_ONE;
            if (pop_ok_i)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // The extra MSB distinguishes full from empty when the low bits match.
    assign count                = wptr_q - rptr_q;
    assign status_o.empty       = (wptr_q == rptr_q);
    assign status_o.full        = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                                  (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign status_o.almost_full = (count >= AF_LVL);
    assign status_o.count       = STATUS_CNT_W'(count);

    assign waddr_o = wptr_q[PTR_W-1:0];
    assign raddr_o = rptr_q[PTR_W-1:0];

endmodule

// File: rtl/multi_channel_fifo.sv
// NUM_CHANNELS independent FIFOs sharing one storage array, indexed by feature channel.
// Latency: push visible in flags next cycle; pop data on o_rdata one cycle after request.
// Backpressure: illegal push/pop is dropped and reported by a one-cycle overflow/underflow pulse.
module multi_channel_fifo
    import cnn_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH        = 32,
    parameter int  CHANNEL_WIDTH     = 11,
    parameter int  NUM_CHANNELS      = 4,
    parameter int  FIFO_DEPTH        = 8,
    parameter int  ALMOST_FULL_LEVEL = 6,
    localparam int PTR_W             = ptr_width(FIFO_DEPTH)
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_wenable,
    input  logic [CHANNEL_WIDTH-1:0]            i_wchannel,
    input  logic [DATA_WIDTH-1:0]               i_wdata,
    input  logic                                i_renable,
    input  logic [CHANNEL_WIDTH-1:0]            i_rchannel,
    input  logic [NUM_CHANNELS-1:0]             i_flush,
    output logic [DATA_WIDTH-1:0]               o_rdata,
    output logic                                o_rvalid,
    output logic [CHANNEL_WIDTH-1:0]            o_rchannel,
    output logic [NUM_CHANNELS-1:0]             o_full,
    output logic [NUM_CHANNELS-1:0]             o_empty,
    output logic [NUM_CHANNELS-1:0]             o_almost_full,
    output logic [NUM_CHANNELS*(PTR_W+1)-1:0]   o_count,
    output logic                                o_overflow,
    output logic                                o_underflow
);

    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = $clog2(NUM_CHANNELS * FIFO_DEPTH);

    ch_status_t                status      [NUM_CHANNELS];
    logic [PTR_W-1:0]          ch_waddr    [NUM_CHANNELS];
    logic [PTR_W-1:0]          ch_raddr    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]   wsel, rsel, push_ok, pop_ok;
    logic [NUM_CHANNELS-1:0]   cnt_hi_unused;
    logic [ADDR_W-1:0]         waddr, raddr;
    logic                      push_any, pop_any;
    logic                      wr_in_range, rd_in_range;
    logic                      ovf_d, udf_d;

    logic [DATA_WIDTH-1:0]     mem_q [NUM_CHANNELS*FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [CHANNEL_WIDTH-1:0]  rchannel_q, rchannel_d;
    logic                      rvalid_q, ovf_q, udf_q;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gen_ch
        fifo_channel_ctrl #(
            .FIFO_DEPTH        (FIFO_DEPTH),
            .ALMOST_FULL_LEVEL (ALMOST_FULL_LEVEL)
        ) u_ctrl (
            .clk_i     (i_clock),
            .rst_ni    (i_reset),
            .push_ok_i (push_ok[c]),
            .pop_ok_i  (pop_ok[c]),
            .flush_i   (i_flush[c]),
            .status_o  (status[c]),
            .waddr_o   (ch_waddr[c]),
            .raddr_o   (ch_raddr[c])
        );

        assign o_full[c]                   = status[c].full;
        assign o_empty[c]                  = status[c].empty;
        assign o_almost_full[c]            = status[c].almost_full;
        assign o_count[c*CNT_W +: CNT_W]   = status[c].count[CNT_W-1:0];
        assign cnt_hi_unused[c]            = |status[c].count[STATUS_CNT_W-1:CNT_W];
    end

    assign wr_in_range = chan_in_range(CH_CMP_W'(i_wchannel), NUM_CHANNELS);
    assign rd_in_range = chan_in_range(CH_CMP_W'(i_rchannel), NUM_CHANNELS);

    // Channel decode doubles as the range check: an out-of-range index selects nothing.
    always_comb begin
        wsel    = '0;
        rsel    = '0;
        push_ok = '0;
        pop_ok  = '0;
        waddr   = '0;
        raddr   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (i_wchannel == CHANNEL_WIDTH'(c)) begin
                wsel[c] = 1'b1;
                waddr   = ADDR_W'(c * FIFO_DEPTH) + ADDR_W'(ch_waddr[c]);
            end
            if (i_rchannel == CHANNEL_WIDTH'(c)) begin
                rsel[c] = 1'b1;
                raddr   = ADDR_W'(c * FIFO_DEPTH) + ADDR_W'(ch_raddr[c]);
            end
            push_ok[c] = i_wenable && wsel[c] && !o_full[c]  && !i_flush[c];
            pop_ok[c]  = i_renable && rsel[c] && !o_empty[c] && !i_flush[c];
        end
    end

    assign push_any = |push_ok;
    assign pop_any  = |pop_ok;

    // Requests swallowed by a flush of their own channel are dropped silently.
    assign ovf_d = i_wenable && !push_any && !(wr_in_range && |(wsel & i_flush));
    assign udf_d = i_renable && !pop_any  && !(rd_in_range && |(rsel & i_flush));

    always_ff @(posedge i_clock) begin
        if (push_any) mem_q[waddr] <= i_wdata;
    end

    always_comb begin
        rdata_d    = rdata_q;
        rchannel_d = rchannel_q;
        if (pop_any) begin
            rdata_d    = mem_q[raddr];
            rchannel_d = i_rchannel;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rdata_q    <= '0;
            rchannel_q <= '0;
            rvalid_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rchannel_q <= rchannel_d;
            rvalid_q   <= pop_any;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_rchannel  = rchannel_q;
    assign o_rvalid    = rvalid_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

endmodule

// File: tb/tb_multi_channel_fifo.sv
// Bench for multi_channel_fifo: directed scenarios plus random traffic against a queue-style model.
module tb_multi_channel_fifo;

    localparam int DW    = 32;
    localparam int CW    = 11;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int CNT_W = 4;

    logic                 i_clock = 1'b0;
    logic                 i_reset;
    logic                 i_wenable;
    logic [CW-1:0]        i_wchannel;
    logic [DW-1:0]        i_wdata;
    logic                 i_renable;
    logic [CW-1:0]        i_rchannel;
    logic [NCH-1:0]       i_flush;
    logic [DW-1:0]        o_rdata;
    logic                 o_rvalid;
    logic [CW-1:0]        o_rchannel;
    logic [NCH-1:0]       o_full, o_empty, o_almost_full;
    logic [NCH*CNT_W-1:0] o_count;
    logic                 o_overflow, o_underflow;

    always #5 i_clock = ~i_clock;

    multi_channel_fifo #(
        .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .NUM_CHANNELS(NCH),
        .FIFO_DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_wenable(i_wenable), .i_wchannel(i_wchannel), .i_wdata(i_wdata),
        .i_renable(i_renable), .i_rchannel(i_rchannel), .i_flush(i_flush),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rchannel(o_rchannel),
        .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
        .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Model: each channel is an ordered list (index 0 = oldest) plus an occupancy.
    logic [DW-1:0] m_data [NCH][DEPTH];
    int            m_cnt  [NCH];
    logic [DW-1:0] m_rdata;
    logic [CW-1:0] m_rch;
    logic          m_rvalid, m_ovf, m_udf;

    always @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
            m_rdata = '0; m_rch = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            int  wc, rc;
            bit  wok, pok;
            wc  = int'(i_wchannel);
            rc  = int'(i_rchannel);
            wok = i_wenable && wc < NCH && m_cnt[wc] < DEPTH && !i_flush[wc];
            pok = i_renable && rc < NCH && m_cnt[rc] > 0 && !i_flush[rc];
            m_ovf    = i_wenable && !wok && !(wc < NCH && i_flush[wc]);
            m_udf    = i_renable && !pok && !(rc < NCH && i_flush[rc]);
            m_rvalid = pok;
            if (pok) begin
                m_rdata = m_data[rc][0];
                m_rch   = i_rchannel;
                for (int k = 0; k < DEPTH-1; k++) m_data[rc][k] = m_data[rc][k+1];
                m_cnt[rc]--;
            end
            if (wok) begin
                m_data[wc][m_cnt[wc]] = i_wdata;
                m_cnt[wc]++;
            end
            for (int c = 0; c < NCH; c++) if (i_flush[c]) m_cnt[c] = 0;
        end
    end

    logic [NCH-1:0]       e_full, e_empty, e_af;
    logic [NCH*CNT_W-1:0] e_count;

    always @(negedge i_clock) begin
        if (chk_on) begin
            for (int c = 0; c < NCH; c++) begin
                e_full[c]                  = (m_cnt[c] == DEPTH);
                e_empty[c]                 = (m_cnt[c] == 0);
                e_af[c]                    = (m_cnt[c] >= AFL);
                e_count[c*CNT_W +: CNT_W]  = CNT_W'(m_cnt[c]);
            end
            chk("full",      64'(o_full),        64'(e_full));
            chk("empty",     64'(o_empty),       64'(e_empty));
            chk("almost",    64'(o_almost_full), 64'(e_af));
            chk("count",     64'(o_count),       64'(e_count));
            chk("rvalid",    64'(o_rvalid),      64'(m_rvalid));
            chk("rdata",     64'(o_rdata),       64'(m_rdata));
            chk("rchannel",  64'(o_rchannel),    64'(m_rch));
            chk("overflow",  64'(o_overflow),    64'(m_ovf));
            chk("underflow", 64'(o_underflow),   64'(m_udf));
        end
    end

    function automatic int cnt_of(input int c);
        return int'(o_count[c*CNT_W +: CNT_W]);
    endfunction

    task automatic drive(input logic we, input int wc, input logic [DW-1:0] wd,
                         input logic re, input int rc, input logic [NCH-1:0] fl);
        @(negedge i_clock);
        #1;
        i_wenable  = we;
        i_wchannel = CW'(wc);
        i_wdata    = wd;
        i_renable  = re;
        i_rchannel = CW'(rc);
        i_flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    initial begin
        i_wenable = 0; i_wchannel = '0; i_wdata = '0;
        i_renable = 0; i_rchannel = '0; i_flush = '0;
        i_reset = 1'b1;
        #1 i_reset = 1'b0;
        #1 chk_on = 1'b1;
        #10;
        chk("rst_empty", 64'(o_empty), 64'hF);
        chk("rst_full",  64'(o_full),  64'h0);
        chk("rst_count", 64'(o_count), 64'h0);
        chk("rst_rdata", 64'(o_rdata), 64'h0);
        #10 i_reset = 1'b1;

        // Fill channel 2 to full, then one rejected push.
        for (int i = 0; i < 5; i++) drive(1, 2, DW'(32'hA0 + i), 0, 0, '0);
        idle();
        chk("af_at5", 64'(o_almost_full[2]), 64'h0);
        chk("cnt2_5", 64'(cnt_of(2)), 64'd5);
        for (int i = 5; i < 8; i++) drive(1, 2, DW'(32'hA0 + i), 0, 0, '0);
        idle();
        chk("full2",  64'(o_full[2]),        64'h1);
        chk("af2",    64'(o_almost_full[2]), 64'h1);
        chk("cnt2_8", 64'(cnt_of(2)),        64'd8);
        drive(1, 2, 32'hEE, 0, 0, '0);
        idle();
        chk("ovf_pulse", 64'(o_overflow), 64'h1);
        idle();
        chk("ovf_clear", 64'(o_overflow), 64'h0);
        chk("cnt2_stay", 64'(cnt_of(2)),  64'd8);

        // Drain channel 2 in order, then one rejected pop.
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, '0, 1, 2, '0);
            idle();
            chk("pop_data", 64'(o_rdata), 64'(32'hA0 + i));
            chk("pop_vld",  64'(o_rvalid), 64'h1);
            chk("pop_ch",   64'(o_rchannel), 64'd2);
        end
        drive(0, 0, '0, 1, 2, '0);
        idle();
        chk("udf_pulse", 64'(o_underflow), 64'h1);
        chk("udf_novld", 64'(o_rvalid),    64'h0);
        chk("udf_hold",  64'(o_rdata),     64'hA7);

        // Interleaved channels 0 and 3.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, DW'(32'h10 + i), 0, 0, '0);
            drive(1, 3, DW'(32'h30 + i), 0, 0, '0);
        end
        idle();
        chk("cnt0_4", 64'(cnt_of(0)), 64'd4);
        chk("cnt3_4", 64'(cnt_of(3)), 64'd4);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 1, 3, '0);
        idle();
        chk("ch3_last", 64'(o_rdata), 64'h33);
        chk("cnt0_kept", 64'(cnt_of(0)), 64'd4);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 1, 0, '0);
        idle();
        chk("ch0_last", 64'(o_rdata), 64'h13);

        // Simultaneous push/pop on empty then full channel 1.
        drive(1, 1, 32'h55, 1, 1, '0);
        idle();
        chk("sim_e_udf", 64'(o_underflow), 64'h1);
        chk("sim_e_cnt", 64'(cnt_of(1)),   64'd1);
        for (int i = 0; i < 7; i++) drive(1, 1, DW'(32'h56 + i), 0, 0, '0);
        drive(1, 1, 32'h99, 1, 1, '0);
        idle();
        chk("sim_f_ovf",  64'(o_overflow), 64'h1);
        chk("sim_f_vld",  64'(o_rvalid),   64'h1);
        chk("sim_f_data", 64'(o_rdata),    64'h55);
        chk("sim_f_cnt",  64'(cnt_of(1)),  64'd7);

        // Flush beats a same-cycle push.
        for (int i = 0; i < 5; i++) drive(1, 0, DW'(32'h70 + i), 0, 0, '0);
        drive(1, 0, 32'h75, 0, 0, 4'b0001);
        idle();
        chk("fl_cnt0",  64'(cnt_of(0)),   64'd0);
        chk("fl_empty", 64'(o_empty[0]),  64'h1);
        chk("fl_noovf", 64'(o_overflow),  64'h0);
        chk("fl_cnt1",  64'(cnt_of(1)),   64'd7);

        // Streaming through channel 0 across pointer wraps, then reset mid-stream.
        drive(0, 0, '0, 0, 0, 4'hF);
        drive(1, 0, 32'h100, 0, 0, '0);
        for (int i = 0; i < 24; i++) begin
            if (i == 22) begin
                @(negedge i_clock);
                #1;
                i_reset = 1'b0;
                i_wenable = 0; i_renable = 0; i_flush = '0;
                #1;
                chk("mid_empty", 64'(o_empty), 64'hF);
                chk("mid_full",  64'(o_full),  64'h0);
                chk("mid_af",    64'(o_almost_full), 64'h0);
                chk("mid_count", 64'(o_count), 64'h0);
                chk("mid_vld",   64'(o_rvalid), 64'h0);
            end else begin
                drive(1, 0, DW'(32'h101 + i), 1, 0, '0);
                if (i == 20) chk("wrap_data", 64'(o_rdata), 64'(32'h100 + 19));
            end
        end
        idle();
        idle();
        @(negedge i_clock);
        #1 i_reset = 1'b1;

        // Random traffic, including out-of-range channels and occasional flushes.
        for (int n = 0; n < 2000; n++) begin
            logic [NCH-1:0] fl;
            fl = ($urandom_range(0, 19) == 0) ? NCH'(1 << $urandom_range(0, NCH-1)) : '0;
            drive(($urandom_range(0, 9) < 6), $urandom_range(0, 5), DW'($urandom),
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 5), fl);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
